forward_tag_pipeline: RTL and testbench
=======================================

# forward_tag_pipeline

Tracks the destination and source register tags of in-flight instructions through the EXE, MEM and WB stages of the 5-stage core. It is the consumer of the ID-stage stall decision: it inserts a bubble into EXE when `hazard_detected` or `flush` is high. It feeds the registered EXE/MEM destination tags back to the hazard detector. It also drives the EXE-stage operand forwarding-mux selects.

## Interface
- `REG_W`, 4: register-tag width.
- `CNT_W`, 16: bubble-counter width.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_dest`  in  REG_W  destination tag of the instruction leaving ID.
- `id_src1`, `id_src2`  in  REG_W  source tags of the instruction leaving ID.
- `id_wb_en`, `id_mem_r_en`, `id_two_src`  in  1  ID-stage control bits.
- `hazard_detected`  in  1  stall request from the hazard detector. The ID instruction is held upstream and a bubble enters EXE.
- `flush`  in  1  taken branch; a bubble enters EXE.
- `forward_en`  in  1  global forwarding enable.
- `exe_dest`, `mem_dest`, `wb_dest`  out  REG_W  registered destination tags per stage.
- `exe_wb_en`, `mem_wb_en`, `wb_wb_en`  out  1  registered write-back enables per stage.
- `exe_mem_r_en`, `mem_mem_r_en`  out  1  registered load flags.
- `sel_src1`, `sel_src2`  out  2  EXE operand mux selects: 00 register file, 01 MEM-stage ALU result, 10 WB-stage write value, 11 never driven.
- `bubble_cnt`  out  CNT_W  saturating count of hazard bubbles.

## Operation
- The pipeline advances unconditionally every cycle; there is no global freeze.
- EXE load, normal case (`hazard_detected`=0 and `flush`=0): EXE tags are loaded from the `id_*` inputs. The EXE stage also holds `exe_src1`, `exe_src2` and `exe_two_src` internally.
- EXE load, bubble case (`hazard_detected`=1 or `flush`=1): all EXE fields are cleared. Dest, src and wb_en, mem_r_en, two_src all become 0.
- Every cycle, MEM takes EXE and WB takes MEM (dest, wb_en, mem_r_en; WB drops mem_r_en).
- `sel_src1` (combinational from registered state):
  - If `forward_en`=0: 00.
  - Else if `mem_wb_en`, `!mem_mem_r_en` and `exe_src1==mem_dest`: 01.
  - Else if `wb_wb_en` and `exe_src1==wb_dest`: 10.
  - Else: 00.
- MEM has priority over WB, because it holds the younger write.
- `sel_src2`: same rule using `exe_src2`, additionally gated by `exe_two_src`. If `exe_two_src`=0, the select is 00.
- MEM-stage load match (`mem_mem_r_en`=1): never forwarded from MEM, since the data is not yet available. This is defensive; the hazard detector already prevents it. The WB check still applies.
- A bubble's tags are all zero with all enables 0. A bubble therefore never matches and never forwards, even against register 0.
- `bubble_cnt` increments by 1 each cycle `hazard_detected`=1. This includes cycles where `flush` is also 1. Flush-only bubbles are not counted. The counter saturates at all-ones.

## Timing
- Reset: every registered tag, enable and internal src field is 0, `bubble_cnt`=0, and hence `sel_src1`/`sel_src2`=00.
- Reset has priority over `hazard_detected` and `flush`. Reset asserted mid-stream clears all stages in one cycle.
- Latency: an instruction accepted at edge N appears in EXE outputs after edge N, in MEM after N+1, and in WB after N+2.
- Selects are valid in the same cycle as the EXE contents they describe. There is no added latency.
- Load-use sequence: load accepted at edge N. Dependent instruction stalled for one cycle at edge N+1, which inserts a bubble. Dependent accepted at edge N+2 with the load in WB, giving `sel`=10.
- Simultaneous `hazard_detected` and `flush`: one bubble, and the counter increments.
- Counter at all-ones with `hazard_detected`=1: value holds.

## Test plan
- Reset: assert `rst` with random inputs for 2 cycles -> all outputs 0, `bubble_cnt`=0, selects 00.
- Back-to-back ALU dependency:
  - Stimulus: issue r3 dest (wb_en=1), then r3 as src1 with `forward_en`=1.
  - Required: second instruction in EXE gives `sel_src1`=01. With `forward_en`=0 -> 00.
- Distance-2 dependency with priority:
  - Stimulus: issue r5 dest, r5 dest, then r5 as src2 with two_src=1.
  - Required: `sel_src2`=01 (MEM wins).
  - Variant: repeat with the middle instruction writing r6 -> 10.
  - Variant: repeat with two_src=0 -> 00.
- Load-use:
  - Stimulus: load to r2, then pulse `hazard_detected` for 1 cycle, then r2 as src1.
  - Required: EXE shows the bubble (all 0), then the dependent arrives with `sel_src1`=10, and `bubble_cnt`=1.
- Flush:
  - Stimulus: assert `flush` with a valid r7-writing instruction on `id_*`.
  - Required: `exe_wb_en`=0 and `exe_dest`=0, no later forwarding of r7, `bubble_cnt` unchanged. Then assert `flush` and `hazard_detected` together -> one bubble, and the count increments.
- Saturation: preload the counter by holding `hazard_detected`=1 for 2^CNT_W+3 cycles (CNT_W=4 for bench) -> `bubble_cnt` ends at 15.

Source files
------------

// File: rtl/forward_tag_pipeline.sv
// ============================================================================
// Module   : forward_tag_pipeline
// Brief    : EXE/MEM/WB register-tag tracking, bubble insertion and EXE operand
//            forwarding-select generation for the 5-stage core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_tag_pipeline #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_dest,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             id_two_src,
    input  logic             hazard_detected,
    input  logic             flush,
    input  logic             forward_en,
    output logic [REG_W-1:0] exe_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest,
    output logic             exe_wb_en,
    output logic             mem_wb_en,
    output logic             wb_wb_en,
    output logic             exe_mem_r_en,
    output logic             mem_mem_r_en,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [1:0]       c_sel_rf  = 2'b00;
    localparam logic [1:0]       c_sel_mem = 2'b01;
    localparam logic [1:0]       c_sel_wb  = 2'b10;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // EXE stage
    logic [REG_W-1:0] r_exe_dest;
    logic [REG_W-1:0] r_exe_src1;
    logic [REG_W-1:0] r_exe_src2;
    logic             r_exe_wb_en;
    logic             r_exe_mem_r_en;
    logic             r_exe_two_src;
    // MEM stage
    logic [REG_W-1:0] r_mem_dest;
    logic             r_mem_wb_en;
    logic             r_mem_mem_r_en;
    // WB stage
    logic [REG_W-1:0] r_wb_dest;
    logic             r_wb_wb_en;

    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_bubble;

    assign w_bubble = hazard_detected | flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exe_dest     <= '0;
            r_exe_src1     <= '0;
            r_exe_src2     <= '0;
            r_exe_wb_en    <= 1'b0;
            r_exe_mem_r_en <= 1'b0;
            r_exe_two_src  <= 1'b0;
            r_mem_dest     <= '0;
            r_mem_wb_en    <= 1'b0;
            r_mem_mem_r_en <= 1'b0;
            r_wb_dest      <= '0;
            r_wb_wb_en     <= 1'b0;
            r_bubble_cnt   <= '0;
        end else begin
            // A bubble zeroes every field so it can never match, even on r0.
            if (w_bubble) begin
                r_exe_dest     <= '0;
                r_exe_src1     <= '0;
                r_exe_src2     <= '0;
                r_exe_wb_en    <= 1'b0;
                r_exe_mem_r_en <= 1'b0;
                r_exe_two_src  <= 1'b0;
            end else begin
                r_exe_dest     <= id_dest;
                r_exe_src1     <= id_src1;
                r_exe_src2     <= id_src2;
                r_exe_wb_en    <= id_wb_en;
                r_exe_mem_r_en <= id_mem_r_en;
                r_exe_two_src  <= id_two_src;
            end

            r_mem_dest     <= r_exe_dest;
            r_mem_wb_en    <= r_exe_wb_en;
            r_mem_mem_r_en <= r_exe_mem_r_en;
            r_wb_dest      <= r_mem_dest;
            r_wb_wb_en     <= r_mem_wb_en;

            // Only stall bubbles are counted; flush-only bubbles are not.
            if (hazard_detected && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    // MEM wins over WB since it holds the younger write; a load still in MEM
    // has no data yet and is never a forwarding source.
    function automatic logic [1:0] f_fwd_sel(
        input logic             fwd_en,
        input logic             src_used,
        input logic [REG_W-1:0] src,
        input logic             mem_wen,
        input logic             mem_load,
        input logic [REG_W-1:0] mem_tag,
        input logic             wb_wen,
        input logic [REG_W-1:0] wb_tag
    );
        logic [1:0] sel;
        sel = c_sel_rf;
        if (fwd_en && src_used) begin
            if (mem_wen && !mem_load && (src == mem_tag)) begin
                sel = c_sel_mem;
            end else if (wb_wen && (src == wb_tag)) begin
                sel = c_sel_wb;
            end
        end
        return sel;
    endfunction

    assign sel_src1 = f_fwd_sel(forward_en, 1'b1, r_exe_src1,
                                r_mem_wb_en, r_mem_mem_r_en, r_mem_dest,
                                r_wb_wb_en, r_wb_dest);
    assign sel_src2 = f_fwd_sel(forward_en, r_exe_two_src, r_exe_src2,
                                r_mem_wb_en, r_mem_mem_r_en, r_mem_dest,
                                r_wb_wb_en, r_wb_dest);

    assign exe_dest     = r_exe_dest;
    assign mem_dest     = r_mem_dest;
    assign wb_dest      = r_wb_dest;
    assign exe_wb_en    = r_exe_wb_en;
    assign mem_wb_en    = r_mem_wb_en;
    assign wb_wb_en     = r_wb_wb_en;
    assign exe_mem_r_en = r_exe_mem_r_en;
    assign mem_mem_r_en = r_mem_mem_r_en;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_forward_tag_pipeline.sv
// ============================================================================
// Module   : tb_forward_tag_pipeline
// Brief    : Directed self-checking bench for forward_tag_pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_forward_tag_pipeline;

    localparam int REG_W = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_dest;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic             id_two_src;
    logic             hazard_detected;
    logic             flush;
    logic             forward_en;
    logic [REG_W-1:0] exe_dest;
    logic [REG_W-1:0] mem_dest;
    logic [REG_W-1:0] wb_dest;
    logic             exe_wb_en;
    logic             mem_wb_en;
    logic             wb_wb_en;
    logic             exe_mem_r_en;
    logic             mem_mem_r_en;
    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic [CNT_W-1:0] bubble_cnt;

    int checks;
    int failures;

    forward_tag_pipeline #(
        .REG_W(REG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_dest         (id_dest),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_wb_en        (id_wb_en),
        .id_mem_r_en     (id_mem_r_en),
        .id_two_src      (id_two_src),
        .hazard_detected (hazard_detected),
        .flush           (flush),
        .forward_en      (forward_en),
        .exe_dest        (exe_dest),
        .mem_dest        (mem_dest),
        .wb_dest         (wb_dest),
        .exe_wb_en       (exe_wb_en),
        .mem_wb_en       (mem_wb_en),
        .wb_wb_en        (wb_wb_en),
        .exe_mem_r_en    (exe_mem_r_en),
        .mem_mem_r_en    (mem_mem_r_en),
        .sel_src1        (sel_src1),
        .sel_src2        (sel_src2),
        .bubble_cnt      (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction on id_* with the given stall/flush state, then clock it in.
    task automatic issue(input logic [3:0] dest, input logic [3:0] s1, input logic [3:0] s2,
                         input logic wb, input logic mr, input logic two,
                         input logic hz, input logic fl);
        id_dest         = dest;
        id_src1         = s1;
        id_src2         = s2;
        id_wb_en        = wb;
        id_mem_r_en     = mr;
        id_two_src      = two;
        hazard_detected = hz;
        flush           = fl;
        tick();
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        forward_en      = 1'b1;
        id_dest         = '0;
        id_src1         = '0;
        id_src2         = '0;
        id_wb_en        = 1'b0;
        id_mem_r_en     = 1'b0;
        id_two_src      = 1'b0;
        hazard_detected = 1'b0;
        flush           = 1'b0;

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            id_dest         = REG_W'($urandom);
            id_src1         = REG_W'($urandom);
            id_src2         = REG_W'($urandom);
            id_wb_en        = 1'($urandom);
            id_mem_r_en     = 1'($urandom);
            id_two_src      = 1'($urandom);
            hazard_detected = 1'b1;
            flush           = 1'($urandom);
        end
        tick();
        chk("rst_dests", {20'd0, exe_dest, mem_dest, wb_dest}, 32'd0);
        chk("rst_enables", {27'd0, exe_wb_en, mem_wb_en, wb_wb_en, exe_mem_r_en, mem_mem_r_en}, 32'd0);
        chk("rst_sels", {28'd0, sel_src1, sel_src2}, 32'd0);
        chk("rst_cnt", {28'd0, bubble_cnt}, 32'd0);
        rst = 1'b0;

        // Back-to-back ALU dependency on r3
        issue(4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_exe_dest", {28'd0, exe_dest}, 32'd3);
        issue(4'd1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_mem_dest", {28'd0, mem_dest}, 32'd3);
        chk("b2b_sel1_mem", {30'd0, sel_src1}, 32'd1);
        forward_en = 1'b0;
        #1;
        chk("b2b_sel1_fwd_off", {30'd0, sel_src1}, 32'd0);
        forward_en = 1'b1;
        #1;

        // Distance-2 on r5: MEM has priority over WB
        issue(4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd9, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("d2_sel2_mem_prio", {30'd0, sel_src2}, 32'd1);
        chk("d2_sel1_none", {30'd0, sel_src1}, 32'd0);

        // Middle instruction writes r6 -> r5 comes from WB
        issue(4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd9, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("d2_sel2_wb", {30'd0, sel_src2}, 32'd2);

        // Single-source instruction never forwards src2
        issue(4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd5, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd9, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("d2_sel2_two_src0", {30'd0, sel_src2}, 32'd0);

        // Load in MEM is never a forwarding source
        issue(4'd4, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'd9, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("load_in_mem_sel1", {30'd0, sel_src1}, 32'd0);
        chk("load_in_mem_flag", {31'd0, mem_mem_r_en}, 32'd1);

        // Load-use: load r2, one stall bubble, then dependent
        issue(4'd2, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_exe_load", {31'd0, exe_mem_r_en}, 32'd1);
        issue(4'd10, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lu_bubble_exe", {25'd0, exe_dest, exe_wb_en, exe_mem_r_en, sel_src1}, 32'd0);
        chk("lu_cnt_1", {28'd0, bubble_cnt}, 32'd1);
        issue(4'd10, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_wb_tag", {27'd0, wb_wb_en, wb_dest}, {27'd0, 1'b1, 4'd2});
        chk("lu_sel1_wb", {30'd0, sel_src1}, 32'd2);
        chk("lu_cnt_hold", {28'd0, bubble_cnt}, 32'd1);

        // Flush kills a valid r7 writer and is not counted
        issue(4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fl_exe_cleared", {27'd0, exe_wb_en, exe_dest}, 32'd0);
        chk("fl_cnt_same", {28'd0, bubble_cnt}, 32'd1);
        issue(4'd11, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fl_no_fwd_mem", {28'd0, sel_src1, sel_src2}, 32'd0);
        issue(4'd11, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("fl_no_fwd_wb", {28'd0, sel_src1, sel_src2}, 32'd0);
        issue(4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("flhz_exe_cleared", {27'd0, exe_wb_en, exe_dest}, 32'd0);
        chk("flhz_cnt_2", {28'd0, bubble_cnt}, 32'd2);

        // Mid-stream reset wins over a simultaneous stall
        issue(4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(4'd4, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        issue(4'd5, 4'd4, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        chk("mrst_dests", {20'd0, exe_dest, mem_dest, wb_dest}, 32'd0);
        chk("mrst_enables", {27'd0, exe_wb_en, mem_wb_en, wb_wb_en, exe_mem_r_en, mem_mem_r_en}, 32'd0);
        chk("mrst_cnt", {28'd0, bubble_cnt}, 32'd0);

        // Saturation: 2^CNT_W + 3 stall cycles
        for (int i = 0; i < 14; i++) begin
            issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("sat_cnt_14", {28'd0, bubble_cnt}, 32'd14);
        for (int i = 0; i < 5; i++) begin
            issue(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("sat_cnt_15", {28'd0, bubble_cnt}, 32'd15);
        hazard_detected = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
